// File: rtl/gate_quad_bist.sv
// BIST sequencer for quad 2-input gate parts: sweeps all 256 A/B input
// combinations, samples Y after a settle time, and tallies mismatches.
`timescale 1ns/1ps

module gate_quad_bist_lane #(
  parameter int FUNC = 0
) (
  input  logic a,
  input  logic b,
  output logic e
);
  always_comb begin
    case (FUNC)
      1:       e = a & b;
      2:       e = ~(a & b);
      3:       e = ~(a | b);
      4:       e = a ^ b;
      default: e = a | b;
    endcase
  end
endmodule

module gate_quad_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int FUNC          = 0
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] dut_a,
  output logic [3:0] dut_b,
  input  logic [3:0] dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] fail_count,
  output logic [7:0] first_fail_vec,
  output logic [3:0] first_fail_y
);
  localparam int NUM_LANES = 4;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t         state, state_nxt;
  logic [7:0]     vec, vec_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic           launch, check, run_nxt, mismatch;
  logic [NUM_LANES-1:0] exp_y;

  // Expected output per gate, from the vector currently on the pins
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gate_quad_bist_lane #(.FUNC(FUNC)) u_lane (
      .a (vec[i]),
      .b (vec[i+4]),
      .e (exp_y[i])
    );
  end

  assign mismatch = (dut_y != exp_y);
  assign run_nxt  = (state_nxt == SETTLE) || (state_nxt == CHECK);

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    check     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (abort && start) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = SETTLE;
          launch    = 1'b1;
          vec_nxt   = 8'd0;
          cnt_nxt   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (abort)             state_nxt = IDLE;
        else if (cnt == 4'd0)  state_nxt = CHECK;
        else                   cnt_nxt   = cnt - 4'd1;
      end
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          check = 1'b1;
          if (vec == 8'hFF) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SETTLE;
            vec_nxt   = vec + 8'd1;
            cnt_nxt   = SETTLE_LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      vec            <= '0;
      cnt            <= '0;
      dut_a          <= '0;
      dut_b          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      first_fail_y   <= '0;
    end else begin
      state <= state_nxt;
      vec   <= vec_nxt;
      cnt   <= cnt_nxt;
      busy  <= run_nxt;
      done  <= (state_nxt == DONE);
      dut_a <= run_nxt ? vec_nxt[3:0] : 4'd0;
      dut_b <= run_nxt ? vec_nxt[7:4] : 4'd0;
      if (launch) begin
        fail_count     <= '0;
        first_fail_vec <= '0;
        first_fail_y   <= '0;
      end else if (check && mismatch) begin
        fail_count <= fail_count + 9'd1;
        if (fail_count == 9'd0) begin
          first_fail_vec <= vec;
          first_fail_y   <= dut_y;
        end
      end
      // pass includes the last vector's own result, decided on the closing edge
      if (check && vec == 8'hFF)
        pass <= (fail_count == 9'd0) && !mismatch;
      else if (state_nxt != DONE)
        pass <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gate_quad_bist.sv
// Self-checking bench for gate_quad_bist: behavioural gate models with
// injectable faults, a whole-sweep reference model, and timing corner cases.
`timescale 1ns/1ps

module tb_gate_quad_bist;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = '0;
  logic [2:0] abort = '0;
  logic       glitch_en = 1'b0;

  logic [3:0] a0, b0, y0, a1, b1, y1, a2, b2, y2;
  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [8:0] fc0, fc1, fc2;
  logic [7:0] fv0, fv1, fv2;
  logic [3:0] fy0, fy1, fy2;

  logic [3:0] mask0 [256];
  logic [3:0] mask1 [256];
  logic [7:0] h1, h2;

  int n_chk = 0;
  int n_fail = 0;
  int sel = 0;

  always #5 clk = ~clk;

  // Gate models: OR part, optionally corrupted per vector; u2 glitches on vector change
  assign y0 = (a0 | b0) ^ mask0[{b0, a0}];
  assign y1 = (a1 | b1) ^ mask1[{b1, a1}];
  assign y2 = (a2 | b2) ^ ((glitch_en && ({b2, a2} != h2)) ? 4'hF : 4'h0);

  always @(negedge clk) begin
    h1 <= {b2, a2};
    h2 <= h1;
  end

  gate_quad_bist #(.SETTLE_CYCLES(1), .FUNC(0)) u0 (
    .clock_50(clk), .reset(rst), .start(start[0]), .abort(abort[0]),
    .dut_a(a0), .dut_b(b0), .dut_y(y0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .first_fail_vec(fv0), .first_fail_y(fy0));

  gate_quad_bist #(.SETTLE_CYCLES(1), .FUNC(4)) u1 (
    .clock_50(clk), .reset(rst), .start(start[1]), .abort(abort[1]),
    .dut_a(a1), .dut_b(b1), .dut_y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_vec(fv1), .first_fail_y(fy1));

  gate_quad_bist #(.SETTLE_CYCLES(3), .FUNC(0)) u2 (
    .clock_50(clk), .reset(rst), .start(start[2]), .abort(abort[2]),
    .dut_a(a2), .dut_b(b2), .dut_y(y2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_count(fc2), .first_fail_vec(fv2), .first_fail_y(fy2));

  logic       busy_s, done_s, pass_s;
  logic [8:0] fc_s;
  logic [7:0] fv_s;
  logic [3:0] fy_s, a_s, b_s;

  always_comb begin
    busy_s = busy0; done_s = done0; pass_s = pass0;
    fc_s = fc0; fv_s = fv0; fy_s = fy0; a_s = a0; b_s = b0;
    case (sel)
      1: begin
        busy_s = busy1; done_s = done1; pass_s = pass1;
        fc_s = fc1; fv_s = fv1; fy_s = fy1; a_s = a1; b_s = b1;
      end
      2: begin
        busy_s = busy2; done_s = done2; pass_s = pass2;
        fc_s = fc2; fv_s = fv2; fy_s = fy2; a_s = a2; b_s = b2;
      end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sweep the first nvec vectors with settled gate outputs only
  function automatic void model(input int s, input int nvec,
                                output int cnt, output int fv, output int fy);
    int av, bv, orv, yv, ev, m;
    cnt = 0; fv = 0; fy = 0;
    for (int v = 0; v < nvec; v++) begin
      av  = v % 16;
      bv  = v / 16;
      orv = av | bv;
      m   = (s == 0) ? int'(mask0[v]) : (s == 1) ? int'(mask1[v]) : 0;
      yv  = orv ^ m;
      ev  = (s == 1) ? (av ^ bv) : orv;
      if (yv != ev) begin
        if (cnt == 0) begin fv = v; fy = yv; end
        cnt++;
      end
    end
  endfunction

  // mode 0 clean, 1 Y4 stuck low, 2 random corruption
  task automatic set_mask(input int s, input int mode);
    logic [3:0] m;
    for (int v = 0; v < 256; v++) begin
      case (mode)
        1:       m = 4'(((v % 16) | (v / 16)) & 8);
        2:       m = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        default: m = 4'd0;
      endcase
      if (s == 1) mask1[v] = m; else mask0[v] = m;
    end
  endtask

  task automatic pulse_start(input int s);
    start[s] = 1'b1;
    tick();
    start[s] = 1'b0;
  endtask

  task automatic do_run(input int s, input int nclk, input int ec, input int ef, input int ey);
    sel = s;
    pulse_start(s);
    chk("busy_after_start", busy_s, 1);
    chk("fc_cleared", fc_s, 0);
    repeat (nclk - 1) tick();
    chk("done_early", done_s, 0);
    tick();
    chk("done_on_time", done_s, 1);
    chk("busy_end", busy_s, 0);
    chk("dut_ab_idle", {a_s, b_s}, 0);
    chk("fail_count", fc_s, ec);
    chk("first_fail_vec", fv_s, ef);
    chk("first_fail_y", fy_s, ey);
    chk("pass", pass_s, (ec == 0));
  endtask

  typedef struct {
    int s;
    int mode;
    int use_model;
    int ec;
    int ef;
    int ey;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int ec, ef, ey;
    tbl[0] = '{0, 0, 0, 0,   0,  0};
    tbl[1] = '{0, 1, 0, 192, 8,  0};
    tbl[2] = '{1, 0, 0, 175, 17, 1};
    tbl[3] = '{0, 2, 1, 0,   0,  0};
    tbl[4] = '{0, 2, 1, 0,   0,  0};
    tbl[5] = '{1, 2, 1, 0,   0,  0};
    tbl[6] = '{0, 2, 1, 0,   0,  0};
    set_mask(0, 0);
    set_mask(1, 0);

    #2;
    sel = 0;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_fc", fc0, 0);
    chk("rst_fv_fy", {fv0, fy0}, 0);
    chk("rst_ab", {a0, b0}, 0);
    #20 rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      set_mask(tbl[i].s, tbl[i].mode);
      if (tbl[i].use_model != 0) model(tbl[i].s, 256, ec, ef, ey);
      else begin ec = tbl[i].ec; ef = tbl[i].ef; ey = tbl[i].ey; end
      do_run(tbl[i].s, 512, ec, ef, ey);
      tick();
    end

    // Abort partway: partial tallies are kept, pins and flags drop
    sel = 0;
    set_mask(0, 1);
    pulse_start(0);
    repeat (100) tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    model(0, 50, ec, ef, ey);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_ab", {a0, b0}, 0);
    chk("abort_fc_hold", fc0, ec);
    chk("abort_fv_hold", fv0, ef);
    tick();

    // start held through most of a run must not retrigger
    start[0] = 1'b1;
    tick();
    repeat (299) tick();
    chk("held_busy", busy0, 1);
    start[0] = 1'b0;
    repeat (212) tick();
    chk("held_done_early", done0, 0);
    tick();
    chk("held_done", done0, 1);
    chk("held_fc", fc0, 192);

    // Restart from DONE clears the previous result
    set_mask(0, 0);
    pulse_start(0);
    chk("rerun_fc_clr", fc0, 0);
    chk("rerun_fv_clr", fv0, 0);
    chk("rerun_done_clr", done0, 0);
    chk("rerun_busy", busy0, 1);
    repeat (512) tick();
    chk("rerun_done", done0, 1);
    chk("rerun_pass", pass0, 1);

    // start+abort in DONE -> IDLE
    start[0] = 1'b1; abort[0] = 1'b1;
    tick();
    start[0] = 1'b0; abort[0] = 1'b0;
    chk("sa_done", done0, 0);
    chk("sa_busy", busy0, 0);
    tick();
    chk("sa_idle", busy0, 0);

    // Asynchronous reset mid-run
    set_mask(0, 1);
    pulse_start(0);
    repeat (300) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_fc", fc0, 0);
    chk("arst_fv_fy", {fv0, fy0}, 0);
    chk("arst_ab", {a0, b0}, 0);
    chk("arst_done_pass", {done0, pass0}, 0);
    #3 rst = 1'b0;
    tick();
    set_mask(0, 0);
    do_run(0, 512, 0, 0, 0);
    tick();

    // Longer settle with a glitch confined to the start of each vector
    glitch_en = 1'b1;
    do_run(2, 1024, 0, 0, 0);
    glitch_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
